// File: rtl/axi_req_cut_soc.sv
// ariane_axi_soc: AXI4 channel payloads and the req_t/resp_t bundles for the SoC port.
// Widths: 64-bit address and data, 4-bit ID, 1-bit user.
// Pure type definitions; no logic, no latency, no flow control of its own.
package ariane_axi_soc;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

// axi_req_cut_chan: 2-entry ordered valid/ready buffer for one AXI channel.
// Latency: 1 cycle in->out when empty; sustains 1 beat/cycle.
// Backpressure: o_in_rdy low only when both entries are full; all outputs come from flops.
// Ports: i_clk/i_rst; producer side i_in_vld/o_in_rdy/i_in_dat; consumer side o_out_vld/i_out_rdy/o_out_dat.
module axi_req_cut_chan #(
  parameter type chan_t = logic
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_in_vld,
  output logic  o_in_rdy,
  input  chan_t i_in_dat,
  output logic  o_out_vld,
  input  logic  i_out_rdy,
  output chan_t o_out_dat
);
  logic [1:0] r_cnt;
  chan_t      r_head;
  chan_t      r_tail;
  logic       w_push;
  logic       w_pop;

  assign o_in_rdy  = (r_cnt != 2'd2);
  assign o_out_vld = (r_cnt != 2'd0);
  assign o_out_dat = r_head;
  assign w_push    = i_in_vld & o_in_rdy;
  assign w_pop     = o_out_vld & i_out_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 2'd1;

      // A push can never coincide with count 2 (in_ready is low there), so the
      // push branch only sees count 0 or 1; the new beat lands in head whenever
      // head is empty or being vacated this cycle.
      if (w_push) begin
        if ((r_cnt == 2'd0) || w_pop) r_head <= i_in_dat;
        else                          r_tail <= i_in_dat;
      end else if (w_pop && (r_cnt == 2'd2)) begin
        r_head <= r_tail;
      end
    end
  end
endmodule

// axi_req_cut_soc: registered cut on all five AXI channels of an ariane_axi_soc req/resp pair.
// Latency: 1 cycle per cut channel (0 when a channel's CUT_x=0); full throughput.
// Backpressure: each cut channel absorbs 2 beats; upstream ready drops only when that channel is full.
// Ports: clk_i, rst_i (async, active-high); slv_req_i/slv_resp_o face the core; mst_req_o/mst_resp_i face the adapter.
module axi_req_cut_soc
  import ariane_axi_soc::*;
#(
  parameter bit CUT_AW = 1'b1,
  parameter bit CUT_W  = 1'b1,
  parameter bit CUT_B  = 1'b1,
  parameter bit CUT_AR = 1'b1,
  parameter bit CUT_R  = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);
  // *_vld / *_dat are consumer-side outputs of each channel, *_rdy is producer-side ready.
  logic     w_aw_vld, w_aw_rdy;
  aw_chan_t w_aw_dat;
  logic     w_w_vld, w_w_rdy;
  w_chan_t  w_w_dat;
  logic     w_b_vld, w_b_rdy;
  b_chan_t  w_b_dat;
  logic     w_ar_vld, w_ar_rdy;
  ar_chan_t w_ar_dat;
  logic     w_r_vld, w_r_rdy;
  r_chan_t  w_r_dat;

  if (CUT_AW) begin : g_aw_cut
    axi_req_cut_chan #(.chan_t(aw_chan_t)) u_aw (
      .i_clk(clk_i), .i_rst(rst_i),
      .i_in_vld(slv_req_i.aw_valid), .o_in_rdy(w_aw_rdy), .i_in_dat(slv_req_i.aw),
      .o_out_vld(w_aw_vld), .i_out_rdy(mst_resp_i.aw_ready), .o_out_dat(w_aw_dat));
  end else begin : g_aw_thru
    assign w_aw_vld = slv_req_i.aw_valid;
    assign w_aw_rdy = mst_resp_i.aw_ready;
    assign w_aw_dat = slv_req_i.aw;
  end

  if (CUT_W) begin : g_w_cut
    axi_req_cut_chan #(.chan_t(w_chan_t)) u_w (
      .i_clk(clk_i), .i_rst(rst_i),
      .i_in_vld(slv_req_i.w_valid), .o_in_rdy(w_w_rdy), .i_in_dat(slv_req_i.w),
      .o_out_vld(w_w_vld), .i_out_rdy(mst_resp_i.w_ready), .o_out_dat(w_w_dat));
  end else begin : g_w_thru
    assign w_w_vld = slv_req_i.w_valid;
    assign w_w_rdy = mst_resp_i.w_ready;
    assign w_w_dat = slv_req_i.w;
  end

  if (CUT_B) begin : g_b_cut
    axi_req_cut_chan #(.chan_t(b_chan_t)) u_b (
      .i_clk(clk_i), .i_rst(rst_i),
      .i_in_vld(mst_resp_i.b_valid), .o_in_rdy(w_b_rdy), .i_in_dat(mst_resp_i.b),
      .o_out_vld(w_b_vld), .i_out_rdy(slv_req_i.b_ready), .o_out_dat(w_b_dat));
  end else begin : g_b_thru
    assign w_b_vld = mst_resp_i.b_valid;
    assign w_b_rdy = slv_req_i.b_ready;
    assign w_b_dat = mst_resp_i.b;
  end

  if (CUT_AR) begin : g_ar_cut
    axi_req_cut_chan #(.chan_t(ar_chan_t)) u_ar (
      .i_clk(clk_i), .i_rst(rst_i),
      .i_in_vld(slv_req_i.ar_valid), .o_in_rdy(w_ar_rdy), .i_in_dat(slv_req_i.ar),
      .o_out_vld(w_ar_vld), .i_out_rdy(mst_resp_i.ar_ready), .o_out_dat(w_ar_dat));
  end else begin : g_ar_thru
    assign w_ar_vld = slv_req_i.ar_valid;
    assign w_ar_rdy = mst_resp_i.ar_ready;
    assign w_ar_dat = slv_req_i.ar;
  end

  if (CUT_R) begin : g_r_cut
    axi_req_cut_chan #(.chan_t(r_chan_t)) u_r (
      .i_clk(clk_i), .i_rst(rst_i),
      .i_in_vld(mst_resp_i.r_valid), .o_in_rdy(w_r_rdy), .i_in_dat(mst_resp_i.r),
      .o_out_vld(w_r_vld), .i_out_rdy(slv_req_i.r_ready), .o_out_dat(w_r_dat));
  end else begin : g_r_thru
    assign w_r_vld = mst_resp_i.r_valid;
    assign w_r_rdy = slv_req_i.r_ready;
    assign w_r_dat = mst_resp_i.r;
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = w_aw_dat;
    mst_req_o.aw_valid = w_aw_vld;
    mst_req_o.w        = w_w_dat;
    mst_req_o.w_valid  = w_w_vld;
    mst_req_o.b_ready  = w_b_rdy;
    mst_req_o.ar       = w_ar_dat;
    mst_req_o.ar_valid = w_ar_vld;
    mst_req_o.r_ready  = w_r_rdy;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_aw_rdy;
    slv_resp_o.ar_ready = w_ar_rdy;
    slv_resp_o.w_ready  = w_w_rdy;
    slv_resp_o.b_valid  = w_b_vld;
    slv_resp_o.b        = w_b_dat;
    slv_resp_o.r_valid  = w_r_vld;
    slv_resp_o.r        = w_r_dat;
  end
endmodule
